// File: rtl/router_in_port_pkg.sv
// Shared types for the router receive port: the packet word layout and the
// receive FSM state encoding.
package router_in_port_pkg;

  localparam int PKT_BYTES = 4;

  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dest;
    logic [23:0] data;
  } pkt_t;

  typedef enum logic [1:0] {
    IDLE,
    B1,
    B2,
    B3
  } rx_state_t;

endpackage

// File: rtl/router_in_port_fifo.sv
// Generic packet FIFO with wrap-around pointers and an explicit count, so any
// DEPTH works. A write while full is accepted when a read frees a slot in the
// same cycle. Reused by the router output queues.
module pkt_fifo
  import router_in_port_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type T = pkt_t,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  T                 wr_data,
  input  logic             rd_en,
  output T                 rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);

  // Storage, pointer and count updates for the accepted write/read this cycle
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_rd) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Register the FIFO state; reset clears contents so the head reads as zero
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/router_in_port.sv
// Router receive port: deserializes 4-byte packets from a Node link, buffers
// them in a FIFO and offers them to the crossbar. free is the credit back to
// the Node and counts both buffered packets and the one being assembled.
module router_in_port
  import router_in_port_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        free,
  input  logic        put,
  input  logic [7:0]  payload,
  output logic [31:0] pkt_out,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic        proto_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ASM_W = (PKT_BYTES - 1) * 8;

  rx_state_t        state_q, state_d;
  logic [ASM_W-1:0] asm_q, asm_d;
  logic             reserved_q, reserved_d;
  logic             proto_err_q, proto_err_d;
  logic             free_q, free_d;

  logic             capture;
  logic             fsm_wr;
  logic             drop;
  logic             start;
  logic             fifo_wr;
  logic             fifo_rd;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  pkt_t             wr_pkt;
  pkt_t             head;
  logic [CNT_W:0]   occ_next;

  assign wr_pkt  = pkt_t'({asm_q, payload});
  assign fifo_rd = !fifo_empty && pkt_ready;
  assign fifo_wr = fsm_wr && (!fifo_full || fifo_rd);

  pkt_fifo #(
    .DEPTH(DEPTH),
    .T    (pkt_t)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (fifo_wr),
    .wr_data(wr_pkt),
    .rd_en  (fifo_rd),
    .rd_data(head),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (fifo_count)
  );

  // Receive FSM state register, plus assembly, reservation, error and credit flops
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      asm_q       <= '0;
      reserved_q  <= 1'b0;
      proto_err_q <= 1'b0;
      free_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      asm_q       <= asm_d;
      reserved_q  <= reserved_d;
      proto_err_q <= proto_err_d;
      free_q      <= free_d;
    end
  end

  // Next receive state: a byte per cycle while put holds, back to IDLE otherwise
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (put && free_q) ? B1 : IDLE;
      B1:      state_d = put ? B2 : IDLE;
      B2:      state_d = put ? B3 : IDLE;
      B3:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: byte capture, packet completion, drops and ignored starts
  always_comb begin
    start   = 1'b0;
    capture = 1'b0;
    fsm_wr  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        start   = put && free_q;
        capture = put && free_q;
        drop    = put && !free_q;
      end
      B1, B2: begin
        capture = put;
        drop    = !put;
      end
      B3: begin
        fsm_wr = put;
        drop   = !put;
      end
      default: ;
    endcase
  end

  // Assembly shift register, slot reservation and sticky protocol error
  always_comb begin
    asm_d       = asm_q;
    reserved_d  = reserved_q;
    proto_err_d = proto_err_q || drop;
    if (capture) asm_d = {asm_q[ASM_W-9:0], payload};
    if (start) reserved_d = 1'b1;
    if (fsm_wr || drop) reserved_d = 1'b0;
  end

  // Credit uses the post-update occupancy so it reacts to this cycle's events
  always_comb begin
    occ_next = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(fifo_wr)
             - (CNT_W + 1)'(fifo_rd) + (CNT_W + 1)'(reserved_d);
    free_d   = occ_next < (CNT_W + 1)'(DEPTH);
  end

  assign free      = free_q;
  assign proto_err = proto_err_q;
  assign pkt_valid = !fifo_empty;
  assign pkt_out   = head;

endmodule

// File: tb/tb_router_in_port.sv
// Directed bench for router_in_port: each task drives one scenario at the
// falling edge and checks the DUT outputs there against hand-computed values.
module tb_router_in_port;

  logic        clock = 1'b0;
  logic        reset;
  logic        free;
  logic        put;
  logic [7:0]  payload;
  logic [31:0] pkt_out;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        proto_err;

  int total = 0;
  int bad   = 0;

  router_in_port #(.DEPTH(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .free     (free),
    .put      (put),
    .payload  (payload),
    .pkt_out  (pkt_out),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  // Drive one packet over 4 falling edges, then drop put; returns at the
  // falling edge right after the posedge that took the 4th byte.
  task automatic drive_stream(input logic [31:0] p);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      put     = 1'b1;
      payload = p[31-8*i -: 8];
    end
    @(negedge clock);
    put     = 1'b0;
    payload = 8'h00;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    put       = 1'b0;
    payload   = 8'h00;
    pkt_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++; if (free !== 1'b1) begin bad++; $display("[TB] FAIL reset_free: got %b expected 1", free); end
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", pkt_valid); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b expected 0", proto_err); end
    total++; if (pkt_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_pkt: got %h expected 00000000", pkt_out); end
  endtask

  task automatic test_single();
    logic [31:0] p;
    p = 32'h12345678;
    pkt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      total++; if (pkt_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_valid_early[%0d]: got %b expected 0", i, pkt_valid); end
      put     = 1'b1;
      payload = p[31-8*i -: 8];
    end
    @(negedge clock);
    put = 1'b0;
    total++; if (pkt_valid !== 1'b1 || pkt_out !== 32'h12345678) begin bad++; $display("[TB] FAIL single_out: got valid=%b pkt=%h expected valid=1 pkt=12345678", pkt_valid, pkt_out); end
    @(negedge clock);
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_one_cycle: got valid=%b expected 0", pkt_valid); end
  endtask

  task automatic test_fill();
    logic [31:0] p;
    pkt_ready = 1'b0;
    drive_stream(32'h9ABCDEF0);
    total++; if (pkt_valid !== 1'b1 || pkt_out !== 32'h9ABCDEF0) begin bad++; $display("[TB] FAIL fill_first: got valid=%b pkt=%h expected valid=1 pkt=9abcdef0", pkt_valid, pkt_out); end
    total++; if (free !== 1'b1) begin bad++; $display("[TB] FAIL fill_free_one: got %b expected 1", free); end
    p = 32'h0FEDCBA9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i == 1) begin
        total++; if (free !== 1'b0) begin bad++; $display("[TB] FAIL fill_free_drop: got %b expected 0", free); end
      end
      total++; if (pkt_out !== 32'h9ABCDEF0) begin bad++; $display("[TB] FAIL fill_hold[%0d]: got %h expected 9abcdef0", i, pkt_out); end
      put     = 1'b1;
      payload = p[31-8*i -: 8];
    end
    @(negedge clock);
    put = 1'b0;
    total++; if (free !== 1'b0 || pkt_out !== 32'h9ABCDEF0 || pkt_valid !== 1'b1) begin bad++; $display("[TB] FAIL fill_full: got free=%b valid=%b pkt=%h expected free=0 valid=1 pkt=9abcdef0", free, pkt_valid, pkt_out); end
  endtask

  task automatic test_drain_refill();
    pkt_ready = 1'b1;
    @(negedge clock);
    pkt_ready = 1'b0;
    total++; if (free !== 1'b1) begin bad++; $display("[TB] FAIL drain_free: got %b expected 1", free); end
    total++; if (pkt_out !== 32'h0FEDCBA9) begin bad++; $display("[TB] FAIL drain_head: got %h expected 0fedcba9", pkt_out); end
    drive_stream(32'hCAFEF00D);
    total++; if (free !== 1'b0) begin bad++; $display("[TB] FAIL refill_full: got free=%b expected 0", free); end
    total++; if (pkt_out !== 32'h0FEDCBA9 || pkt_valid !== 1'b1) begin bad++; $display("[TB] FAIL refill_head: got valid=%b pkt=%h expected valid=1 pkt=0fedcba9", pkt_valid, pkt_out); end
    pkt_ready = 1'b1;
    @(negedge clock);
    total++; if (pkt_out !== 32'hCAFEF00D || pkt_valid !== 1'b1) begin bad++; $display("[TB] FAIL refill_order: got valid=%b pkt=%h expected valid=1 pkt=cafef00d", pkt_valid, pkt_out); end
    @(negedge clock);
    total++; if (pkt_valid !== 1'b0 || free !== 1'b1) begin bad++; $display("[TB] FAIL refill_empty: got valid=%b free=%b expected valid=0 free=1", pkt_valid, free); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] s;
    s = 64'h51617181_F2F3F4F5;
    pkt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      total++; if (free !== 1'b1) begin bad++; $display("[TB] FAIL b2b_free[%0d]: got %b expected 1", i, free); end
      if (i == 4) begin
        total++; if (pkt_valid !== 1'b1 || pkt_out !== 32'h51617181) begin bad++; $display("[TB] FAIL b2b_first: got valid=%b pkt=%h expected valid=1 pkt=51617181", pkt_valid, pkt_out); end
      end
      if (i == 5) begin
        total++; if (pkt_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_gap: got valid=%b expected 0", pkt_valid); end
      end
      put     = 1'b1;
      payload = s[63-8*i -: 8];
    end
    @(negedge clock);
    put = 1'b0;
    total++; if (pkt_valid !== 1'b1 || pkt_out !== 32'hF2F3F4F5) begin bad++; $display("[TB] FAIL b2b_second: got valid=%b pkt=%h expected valid=1 pkt=f2f3f4f5", pkt_valid, pkt_out); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("[TB] FAIL b2b_err: got %b expected 0", proto_err); end
    @(negedge clock);
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drained: got valid=%b expected 0", pkt_valid); end
  endtask

  task automatic test_proto_err();
    pkt_ready = 1'b1;
    @(negedge clock);
    put = 1'b1; payload = 8'hDE;
    @(negedge clock);
    payload = 8'hAD;
    @(negedge clock);
    put = 1'b0; payload = 8'h00;
    @(negedge clock);
    total++; if (proto_err !== 1'b1) begin bad++; $display("[TB] FAIL err_set: got %b expected 1", proto_err); end
    total++; if (pkt_valid !== 1'b0 || free !== 1'b1) begin bad++; $display("[TB] FAIL err_nothing_queued: got valid=%b free=%b expected valid=0 free=1", pkt_valid, free); end
    drive_stream(32'h01020304);
    total++; if (pkt_valid !== 1'b1 || pkt_out !== 32'h01020304) begin bad++; $display("[TB] FAIL err_recover: got valid=%b pkt=%h expected valid=1 pkt=01020304", pkt_valid, pkt_out); end
    total++; if (proto_err !== 1'b1) begin bad++; $display("[TB] FAIL err_sticky: got %b expected 1", proto_err); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_packet();
    pkt_ready = 1'b0;
    drive_stream(32'h11223344);
    total++; if (pkt_valid !== 1'b1 || pkt_out !== 32'h11223344) begin bad++; $display("[TB] FAIL rst_buffered: got valid=%b pkt=%h expected valid=1 pkt=11223344", pkt_valid, pkt_out); end
    @(negedge clock);
    put = 1'b1; payload = 8'h55;
    @(negedge clock);
    payload = 8'h66;
    @(negedge clock);
    reset = 1'b1; payload = 8'h77;
    @(negedge clock);
    reset = 1'b0; put = 1'b0; payload = 8'h00;
    total++; if (pkt_valid !== 1'b0 || free !== 1'b1 || proto_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid: got valid=%b free=%b err=%b expected valid=0 free=1 err=0", pkt_valid, free, proto_err); end
    pkt_ready = 1'b1;
    drive_stream(32'h05EAF00D);
    total++; if (pkt_valid !== 1'b1 || pkt_out !== 32'h05EAF00D) begin bad++; $display("[TB] FAIL rst_after: got valid=%b pkt=%h expected valid=1 pkt=05eaf00d", pkt_valid, pkt_out); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_after_err: got %b expected 0", proto_err); end
    @(negedge clock);
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_after_drain: got valid=%b expected 0", pkt_valid); end
  endtask

  initial begin
    $display("[TB] starting router_in_port directed tests");
    test_reset();
    test_single();
    test_fill();
    test_drain_refill();
    test_back_to_back();
    test_proto_err();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
